// File: rtl/core_pkg.sv
// Shared constants for the hazard/forwarding controller: operand-select codes,
// register-index width and the multi-cycle sequencer state encoding.
package core_pkg;

  localparam int REG_AW = 5;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef enum logic {
    MC_IDLE = 1'b0,
    MC_BUSY = 1'b1
  } mc_state_e;

endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline-side bundle for hazard_unit: register indices and control in, stall/flush/forward out.
// HAZARD_PERF_EN adds the three performance-counter outputs.
interface hazard_unit_if #(
  parameter int REG_AW = core_pkg::REG_AW
`ifdef HAZARD_PERF_EN
  , parameter int PERF_W = 32
`endif
);

  logic [REG_AW-1:0] Rs1D, Rs2D;
  logic [REG_AW-1:0] Rs1E, Rs2E;
  logic [REG_AW-1:0] RdE, RdM, RdW;
  logic              RegWriteM, RegWriteW;
  logic              LoadE;
  logic              PCSrcE;
  logic              McStartE;

  logic              StallF, StallD, StallE;
  logic              FlushD, FlushE, FlushM;
  logic [1:0]        ForwardAE, ForwardBE;
  logic              McBusy;
  logic              McDone;

`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] PerfStallCnt, PerfFlushCnt, PerfMcCnt;
`endif

  // Pipeline side: drives indices/control, observes hazard decisions.
  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output RegWriteM, RegWriteW, LoadE, PCSrcE, McStartE,
    input  StallF, StallD, StallE, FlushD, FlushE, FlushM,
    input  ForwardAE, ForwardBE, McBusy, McDone
`ifdef HAZARD_PERF_EN
    , input PerfStallCnt, PerfFlushCnt, PerfMcCnt
`endif
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  RegWriteM, RegWriteW, LoadE, PCSrcE, McStartE,
    output StallF, StallD, StallE, FlushD, FlushE, FlushM,
    output ForwardAE, ForwardBE, McBusy, McDone
`ifdef HAZARD_PERF_EN
    , output PerfStallCnt, PerfFlushCnt, PerfMcCnt
`endif
  );

endinterface

// File: rtl/mc_sequencer.sv
// Multi-cycle Execute sequencer: holds the pipeline while a MUL/DIV op occupies E for
// MC_LAT cycles and pulses mc_done in the cycle the result is valid and E is released.
module mc_sequencer
  import core_pkg::*;
#(
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mc_start,
  output logic mc_stall,
  output logic mc_busy,
  output logic mc_done,
  output logic mc_active
);

  localparam logic [CNT_W-1:0] CNT_LOAD = (MC_LAT > 1) ? CNT_W'(MC_LAT - 2) : '0;

  mc_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MC_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The start cycle stalls combinationally; BUSY covers the remaining MC_LAT-1 cycles,
  // the last of which (cnt == 0) is the release cycle with mc_done and no stall.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mc_stall = 1'b0;
    mc_busy  = 1'b0;
    mc_done  = 1'b0;
    case (state_q)
      MC_IDLE: begin
        if (mc_start) begin
          if (MC_LAT > 1) begin
            mc_stall = 1'b1;
            state_d  = MC_BUSY;
            cnt_d    = CNT_LOAD;
          end else begin
            mc_done = 1'b1;
          end
        end
      end
      MC_BUSY: begin
        if (cnt_q == '0) begin
          mc_done = 1'b1;
          state_d = MC_IDLE;
        end else begin
          mc_stall = 1'b1;
          mc_busy  = 1'b1;
          cnt_d    = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = MC_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign mc_active = (state_q == MC_BUSY);

endmodule

// File: rtl/hazard_unit.sv
// Hazard and forwarding controller for the 5-stage core: E-stage operand forwarding,
// load-use stalls, branch flushes and multi-cycle stall sequencing. HAZARD_PERF_EN adds perf counters.
module hazard_unit
  import core_pkg::*;
#(
  parameter int REG_AW = core_pkg::REG_AW,
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 4
`ifdef HAZARD_PERF_EN
  , parameter int PERF_W = 32
`endif
) (
  input  logic          CLK,
  input  logic          RST_N,
  hazard_unit_if.slave  hz
);

  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  logic       mc_stall, mc_busy, mc_done, mc_active;
  logic       lw_stall;
  logic       stall_f;
  logic [3:0] fwd_all;
  logic [REG_AW-1:0] rs_e [2];

  mc_sequencer #(
    .MC_LAT (MC_LAT),
    .CNT_W  (CNT_W)
  ) u_mc_seq (
    .clk       (CLK),
    .rst_n     (RST_N),
    .mc_start  (hz.McStartE),
    .mc_stall  (mc_stall),
    .mc_busy   (mc_busy),
    .mc_done   (mc_done),
    .mc_active (mc_active)
  );

  assign rs_e[0] = hz.Rs1E;
  assign rs_e[1] = hz.Rs2E;

  // M holds the younger result, so it wins over W when both match.
  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    logic [1:0] sel;
    always_comb begin
      sel = FWD_RF;
      if (hz.RegWriteM && (hz.RdM != REG_ZERO) && (hz.RdM == rs_e[gi])) begin
        sel = FWD_M;
      end else if (hz.RegWriteW && (hz.RdW != REG_ZERO) && (hz.RdW == rs_e[gi])) begin
        sel = FWD_W;
      end
    end
    assign fwd_all[gi*2 +: 2] = sel;
  end

  assign hz.ForwardAE = fwd_all[1:0];
  assign hz.ForwardBE = fwd_all[3:2];

  // While the sequencer owns E, D is already held, so a load-use match is irrelevant.
  always_comb begin
    lw_stall = 1'b0;
    if (hz.LoadE && (hz.RdE != REG_ZERO) &&
        ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D)) && !mc_active) begin
      lw_stall = 1'b1;
    end
  end

  // A redirect squashes the load-use victim anyway, so flushing beats stalling.
  assign stall_f     = mc_stall || (lw_stall && !hz.PCSrcE);
  assign hz.StallF   = stall_f;
  assign hz.StallD   = stall_f;
  assign hz.StallE   = mc_stall;
  assign hz.FlushD   = hz.PCSrcE;
  assign hz.FlushE   = hz.PCSrcE || lw_stall;
  assign hz.FlushM   = mc_stall;
  assign hz.McBusy   = mc_busy;
  assign hz.McDone   = mc_done;

`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] perf_stall_q, perf_stall_d;
  logic [PERF_W-1:0] perf_flush_q, perf_flush_d;
  logic [PERF_W-1:0] perf_mc_q, perf_mc_d;

  always_comb begin
    perf_stall_d = perf_stall_q + PERF_W'(stall_f);
    perf_flush_d = perf_flush_q + PERF_W'(hz.PCSrcE);
    perf_mc_d    = perf_mc_q + PERF_W'(mc_done);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
      perf_mc_q    <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
      perf_mc_q    <= perf_mc_d;
    end
  end

  assign hz.PerfStallCnt = perf_stall_q;
  assign hz.PerfFlushCnt = perf_flush_q;
  assign hz.PerfMcCnt    = perf_mc_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit (MC_LAT = 4): directed scenarios plus randomized cycles
// compared against an occupancy-based reference model.
module tb_hazard_unit;
  import core_pkg::*;

  localparam int LAT = 4;

  logic CLK = 1'b0;
  logic RST_N;
  int   checks = 0;
  int   failures = 0;
  int   mc_age = -1;   // cycles the current multi-cycle op has spent in E, -1 when none

  hazard_unit_if #(.REG_AW(5)) hz_if ();

  hazard_unit #(.MC_LAT(LAT), .CNT_W(4)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .hz    (hz_if)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    hz_if.Rs1D = '0; hz_if.Rs2D = '0; hz_if.Rs1E = '0; hz_if.Rs2E = '0;
    hz_if.RdE = '0; hz_if.RdM = '0; hz_if.RdW = '0;
    hz_if.RegWriteM = 1'b0; hz_if.RegWriteW = 1'b0;
    hz_if.LoadE = 1'b0; hz_if.PCSrcE = 1'b0; hz_if.McStartE = 1'b0;
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (hz_if.RegWriteM && hz_if.RdM != 0 && hz_if.RdM == rs) return 2'b10;
    if (hz_if.RegWriteW && hz_if.RdW != 0 && hz_if.RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  // Checks every output for the inputs currently driven, then advances the model by one clock.
  task automatic cycle_check(input string tag);
    int   age;
    bit   stall, busy, done, lw, st_f;
    #1;
    age   = (mc_age < 0 && hz_if.McStartE) ? 0 : mc_age;
    stall = (age >= 0) && (age <= LAT - 2);
    busy  = (age >= 1) && (age <= LAT - 2);
    done  = (age == LAT - 1);
    lw    = hz_if.LoadE && hz_if.RdE != 0 && (hz_if.RdE == hz_if.Rs1D || hz_if.RdE == hz_if.Rs2D)
            && !(age >= 1);
    st_f  = stall || (lw && !hz_if.PCSrcE);
    chk({tag, ".ForwardAE"}, 32'(hz_if.ForwardAE), 32'(ref_fwd(hz_if.Rs1E)));
    chk({tag, ".ForwardBE"}, 32'(hz_if.ForwardBE), 32'(ref_fwd(hz_if.Rs2E)));
    chk({tag, ".StallF"}, 32'(hz_if.StallF), 32'(st_f));
    chk({tag, ".StallD"}, 32'(hz_if.StallD), 32'(st_f));
    chk({tag, ".StallE"}, 32'(hz_if.StallE), 32'(stall));
    chk({tag, ".FlushD"}, 32'(hz_if.FlushD), 32'(hz_if.PCSrcE));
    chk({tag, ".FlushE"}, 32'(hz_if.FlushE), 32'(hz_if.PCSrcE || lw));
    chk({tag, ".FlushM"}, 32'(hz_if.FlushM), 32'(stall));
    chk({tag, ".McBusy"}, 32'(hz_if.McBusy), 32'(busy));
    chk({tag, ".McDone"}, 32'(hz_if.McDone), 32'(done));
    $display("cycle %s: StallF=%b FlushD=%b FlushE=%b StallE=%b FwdA=%b FwdB=%b McBusy=%b McDone=%b",
             tag, hz_if.StallF, hz_if.FlushD, hz_if.FlushE, hz_if.StallE,
             hz_if.ForwardAE, hz_if.ForwardBE, hz_if.McBusy, hz_if.McDone);
    if (age >= 0) begin
      mc_age = age + 1;
      if (mc_age >= LAT) mc_age = -1;
    end
    @(negedge CLK);
  endtask

  initial begin
    logic [3:0] exp_stall_e;
    logic [3:0] exp_busy;
    logic [3:0] exp_done;

    RST_N = 1'b0;
    drive_idle();
    #2;
    chk("reset.McBusy", 32'(hz_if.McBusy), 32'd0);
    chk("reset.McDone", 32'(hz_if.McDone), 32'd0);
    chk("reset.StallE", 32'(hz_if.StallE), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;

    // Forwarding priority and x0 exclusion
    hz_if.RdM = 5; hz_if.RdW = 5; hz_if.RegWriteM = 1; hz_if.RegWriteW = 1; hz_if.Rs1E = 5;
    #1 chk("fwd_m.ForwardAE", 32'(hz_if.ForwardAE), 32'b10);
    cycle_check("fwd_m");
    hz_if.RegWriteM = 0;
    #1 chk("fwd_w.ForwardAE", 32'(hz_if.ForwardAE), 32'b01);
    cycle_check("fwd_w");
    hz_if.RegWriteM = 1; hz_if.RdM = 0; hz_if.RdW = 0; hz_if.Rs1E = 0;
    #1 chk("fwd_x0.ForwardAE", 32'(hz_if.ForwardAE), 32'b00);
    cycle_check("fwd_x0");

    // Load-use: one stall cycle, then the dependent advances behind a bubble
    drive_idle();
    hz_if.LoadE = 1; hz_if.RdE = 7; hz_if.Rs2D = 7;
    #1 chk("lw.StallF", 32'(hz_if.StallF), 32'd1);
    chk("lw.FlushE", 32'(hz_if.FlushE), 32'd1);
    cycle_check("lw_hit");
    drive_idle();
    cycle_check("lw_after");
    hz_if.LoadE = 1; hz_if.RdE = 7; hz_if.Rs1D = 8; hz_if.Rs2D = 8;
    #1 chk("lw_miss.StallF", 32'(hz_if.StallF), 32'd0);
    cycle_check("lw_miss");

    // Branch alone, then branch colliding with a load-use match
    drive_idle();
    hz_if.PCSrcE = 1;
    cycle_check("branch");
    hz_if.LoadE = 1; hz_if.RdE = 9; hz_if.Rs1D = 9;
    #1 chk("br_lw.StallF", 32'(hz_if.StallF), 32'd0);
    chk("br_lw.FlushD", 32'(hz_if.FlushD), 32'd1);
    cycle_check("branch_lw");

    // Multi-cycle op held in E for LAT cycles; one busy cycle also sees a masked load-use match
    drive_idle();
    exp_stall_e = 4'b0111;
    exp_busy    = 4'b0110;
    exp_done    = 4'b1000;
    for (int k = 0; k < LAT; k++) begin
      hz_if.McStartE = 1;
      hz_if.LoadE = (k == 1); hz_if.RdE = (k == 1) ? 5'd3 : 5'd0; hz_if.Rs1D = 3;
      #1;
      chk($sformatf("mc%0d.StallE", k), 32'(hz_if.StallE), 32'(exp_stall_e[k]));
      chk($sformatf("mc%0d.McBusy", k), 32'(hz_if.McBusy), 32'(exp_busy[k]));
      chk($sformatf("mc%0d.McDone", k), 32'(hz_if.McDone), 32'(exp_done[k]));
      cycle_check($sformatf("mc%0d", k));
    end
    drive_idle();
    cycle_check("mc_after");

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      hz_if.Rs1D = 5'($urandom_range(0, 3)); hz_if.Rs2D = 5'($urandom_range(0, 3));
      hz_if.Rs1E = 5'($urandom_range(0, 3)); hz_if.Rs2E = 5'($urandom_range(0, 3));
      hz_if.RdE  = 5'($urandom_range(0, 3)); hz_if.RdM  = 5'($urandom_range(0, 3));
      hz_if.RdW  = 5'($urandom_range(0, 3));
      hz_if.RegWriteM = 1'($urandom_range(0, 1)); hz_if.RegWriteW = 1'($urandom_range(0, 1));
      if (mc_age >= 0) begin
        hz_if.McStartE = 1; hz_if.LoadE = 0; hz_if.PCSrcE = 0;
      end else begin
        hz_if.McStartE = ($urandom_range(0, 7) == 0);
        hz_if.LoadE    = !hz_if.McStartE && ($urandom_range(0, 2) == 0);
        hz_if.PCSrcE   = !hz_if.McStartE && ($urandom_range(0, 5) == 0);
      end
      cycle_check($sformatf("rnd%0d", n));
    end

    // Asynchronous reset in the second busy cycle aborts the op
    drive_idle();
    mc_age = -1;
    hz_if.McStartE = 1;
    cycle_check("rst_mc0");
    cycle_check("rst_mc1");
    #2;
    RST_N = 1'b0; hz_if.McStartE = 0;
    #1;
    chk("rst_mid.McBusy", 32'(hz_if.McBusy), 32'd0);
    chk("rst_mid.McDone", 32'(hz_if.McDone), 32'd0);
    mc_age = -1;
    @(negedge CLK);
    RST_N = 1'b1;
    for (int k = 0; k < 4; k++) cycle_check($sformatf("rst_post%0d", k));

`ifdef HAZARD_PERF_EN
    RST_N = 1'b0;
    #1;
    chk("perf_rst.Stall", hz_if.PerfStallCnt, 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    mc_age = -1;
    for (int k = 0; k < 2; k++) begin
      drive_idle();
      hz_if.LoadE = 1; hz_if.RdE = 4; hz_if.Rs1D = 4;
      cycle_check($sformatf("perf_lw%0d", k));
      drive_idle();
      cycle_check($sformatf("perf_gap%0d", k));
    end
    for (int k = 0; k < LAT; k++) begin
      hz_if.McStartE = 1;
      cycle_check($sformatf("perf_mc%0d", k));
    end
    drive_idle();
    hz_if.PCSrcE = 1;
    cycle_check("perf_br");
    drive_idle();
    cycle_check("perf_end");
    chk("perf.StallCnt", hz_if.PerfStallCnt, 32'd5);
    chk("perf.FlushCnt", hz_if.PerfFlushCnt, 32'd1);
    chk("perf.McCnt", hz_if.PerfMcCnt, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
